demux_dispatch: RTL
===================

# demux_dispatch

Buffered dispatcher that sits directly upstream of the 1:4 demultiplexer tree (`fourDeMux`). It accepts tagged data words over a valid/ready handshake and queues them in a small FIFO. For the head word it drives the demux select/strobe lines and a one-hot per-destination valid, then pops the word when the addressed consumer accepts it. A watchdog discards a head word whose consumer stalls too long, so the other three destinations are not blocked indefinitely.

## Interface
- `DATA_W`, default 8: width of each data word.
- `DEPTH`, default 4: FIFO entries; power of two, minimum 2.
- `TIMEOUT`, default 16: stall cycles before the head word is dropped; 0 disables the watchdog.

- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: upstream word present.
- `in_ready`, output, 1: FIFO can accept a word.
- `in_data`, input, DATA_W: upstream word.
- `in_dest`, input, 2: destination 0..3.
- `out_valid`, output, 4: one-hot; bit `dest` of the head word is set while it is offered.
- `out_data`, output, DATA_W: head word, shared by all destinations.
- `out_ready`, input, 4: per-destination accept.
- `dmx_i`, output, 1: demux strobe; equals `|out_valid`.
- `dmx_sel0`, output, 1: `dest[1]` of the head word; feeds the first demux stage.
- `dmx_sel1`, output, 1: `dest[0]` of the head word; feeds the second demux stage.
- `drop`, output, 1: one-cycle pulse when the watchdog discards the head word.
- `drop_dest`, output, 2: destination of the dropped word; valid while `drop`=1.
- `level`, output, $clog2(DEPTH)+1: current FIFO occupancy.

## Operation
- **Push:** occurs when `in_valid && in_ready`. The word and its destination are written at the write pointer. `in_ready` is registered and equals `level < DEPTH` for the next cycle.
- **FSM** (state encoding lives in the package):
  - IDLE: FIFO empty. `out_valid`=0.
  - OFFER: head word is presented.
    - Pop when `out_ready[dest]`=1. Go to IDLE if that pop empties the FIFO, otherwise stay in OFFER.
    - Without acceptance, `wait_cnt` increments. When `wait_cnt` reaches `TIMEOUT`-1 with `out_ready[dest]`=0, go to DROP.
  - DROP: `out_valid`=0, `drop`=1, `drop_dest` = head destination. The head word is popped. Next state is OFFER if words remain, otherwise IDLE.
- `wait_cnt` clears on every pop and on every entry into OFFER.
- Ready bits of non-addressed destinations are ignored.
- **Simultaneous push and pop:** both take effect and `level` is unchanged. When full, `in_ready`=0, so no push can occur even if a pop happens in the same cycle. `in_ready` rises the cycle after the pop.
- **Pointers:** wrap modulo DEPTH. Full/empty are distinguished by `level`, not by pointer equality.

## Timing
- **Reset values:** all outputs 0 (including `in_ready`), state IDLE, pointers, `level` and `wait_cnt` at 0. `in_ready` rises on the first clock edge after `rst_n` deasserts.
- **Reset mid-operation:** FIFO contents are discarded immediately and asynchronously. No `drop` pulse is produced.
- **Latency:** a word pushed into an empty FIFO at edge N is offered (`out_valid`, `dmx_*` valid) after edge N+1. There is no combinational input→output bypass.
- **Back-to-back output:** a pop at edge M with further words queued offers the next word immediately after edge M. This gives one word per cycle sustained.
- **Watchdog:** the head word is offered for exactly `TIMEOUT` cycles. DROP occupies one cycle with `out_valid`=0.
- All outputs come from registers or from the FIFO head decode; nothing depends combinationally on `out_ready`.

## Structure
- Package `demux_dispatch_pkg` contains:
  - the state enum `{IDLE, OFFER, DROP}`;
  - the `dest_t` typedef (2-bit);
  - the FIFO entry struct `{dest_t dest; logic [DATA_W-1:0] data}`, parameterised via a localparam default.
- One sub-module, `sync_fifo`:
  - parameters DEPTH and WIDTH;
  - ports for push, pop, head, level and full.
- The FSM, watchdog and select decode sit in the top module.

## Test plan
- **Reset/latency:** hold `rst_n`=0 then release. `in_ready`=0 until the first edge, then 1. Push 0xA5 dest 2; next cycle `out_valid`=4'b0100, `dmx_sel0`=1, `dmx_sel1`=0, `out_data`=0xA5.
- **Fill/full:** keep `out_ready`=0 and push DEPTH=4 words. `level`=4 and `in_ready`=0. A fifth `in_valid` is ignored.
- **Routing order:** push dests 0,1,2,3 with data 0x10..0x13 and `out_ready`=4'hF. Words emerge in order, one per cycle, with matching one-hot `out_valid`; `level` returns to 0.
- **Watchdog:** TIMEOUT=16, push to dest 1, `out_ready`=0. After 16 offer cycles, `drop`=1 for one cycle with `drop_dest`=1. The next queued word is then offered.
- **Simultaneous push/pop:** at `level`=2, push and accept in the same cycle. `level` stays 2 and data order is preserved.
- **Mid-operation reset:** assert `rst_n`=0 with 3 words queued. Outputs go to 0 asynchronously. After release `level`=0 and there is no `drop` pulse.

Source files
------------

// File: rtl/demux_dispatch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : demux_dispatch_pkg
// Description : Shared types for the demux dispatcher. It holds the dispatcher
//               state encoding, the destination type, the FIFO entry layout
//               (default data width) and the one-hot destination decode.
// Revision    : 1.0 - initial release
// ============================================================================
package demux_dispatch_pkg;

    localparam int unsigned c_NUM_DEST   = 4;
    localparam int unsigned c_DATA_W_DEF = 8;

    typedef logic [1:0] dest_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        DROP  = 2'd2
    } state_t;

    typedef struct packed {
        dest_t                   dest;
        logic [c_DATA_W_DEF-1:0] data;
    } entry_t;

    function automatic logic [c_NUM_DEST-1:0] dest_onehot(input dest_t d);
        dest_onehot = 4'b0001 << d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with a registered occupancy count. Full and
//               empty are derived from the count, so the pointers simply wrap.
//               The head word is read combinationally from the read pointer.
// Ports       : clk, rst_n      - clock, async active-low reset
//               push, push_data - write strobe and word (ignored when full)
//               pop             - drop the head word (ignored when empty)
//               head            - current head word
//               level, full     - occupancy and full flag
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo
    import demux_dispatch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_LVL_W = c_PTR_W + 1;

    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
    localparam logic [c_LVL_W-1:0] c_LVL_ONE  = c_LVL_W'(1);
    localparam logic [c_LVL_W-1:0] c_LVL_FULL = c_LVL_W'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_LVL_W-1:0] r_level;
    logic               w_push;
    logic               w_pop;

    assign w_push = push && (r_level != c_LVL_FULL);
    assign w_pop  = pop && (r_level != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_LVL_ONE;
                2'b01:   r_level <= r_level - c_LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked entirely by r_level.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= push_data;
        end
    end

    assign head  = r_mem[r_rptr];
    assign level = r_level;
    assign full  = (r_level == c_LVL_FULL);

endmodule
`default_nettype wire

// File: rtl/demux_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : demux_dispatch
// Description : Buffered dispatcher feeding a 1:4 demux tree. Tagged words are
//               queued in a FIFO; the head word is offered to its destination
//               with a one-hot valid plus demux select/strobe lines, and popped
//               when that destination accepts. A watchdog discards a head word
//               whose destination stalls for TIMEOUT cycles (0 = disabled).
// Ports       : clk, rst_n                  - clock, async active-low reset
//               in_valid/in_ready/in_data/in_dest - upstream handshake
//               out_valid/out_data/out_ready - per-destination handshake
//               dmx_i, dmx_sel0, dmx_sel1    - demux strobe and selects
//               drop, drop_dest              - watchdog discard pulse
//               level                        - FIFO occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module demux_dispatch
    import demux_dispatch_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_data,
    input  logic [1:0]             in_dest,
    output logic [3:0]             out_valid,
    output logic [DATA_W-1:0]      out_data,
    input  logic [3:0]             out_ready,
    output logic                   dmx_i,
    output logic                   dmx_sel0,
    output logic                   dmx_sel1,
    output logic                   drop,
    output logic [1:0]             drop_dest,
    output logic [$clog2(DEPTH):0] level
);

    localparam int c_LVL_W       = $clog2(DEPTH) + 1;
    localparam int c_ENT_W       = DATA_W + 2;
    localparam int c_WCNT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int c_WAIT_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    localparam logic [c_LVL_W-1:0]  c_LVL_ONE   = c_LVL_W'(1);
    localparam logic [c_LVL_W-1:0]  c_LVL_FULL  = c_LVL_W'(DEPTH);
    localparam logic [c_WCNT_W-1:0] c_WAIT_ONE  = c_WCNT_W'(1);
    localparam logic [c_WCNT_W-1:0] c_WAIT_LAST = c_WCNT_W'(c_WAIT_LAST_I);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_WCNT_W-1:0] r_wait_cnt;
    logic                r_in_ready;

    logic [c_ENT_W-1:0]  w_head;
    dest_t               w_head_dest;
    logic [DATA_W-1:0]   w_head_data;
    logic [c_LVL_W-1:0]  w_level;
    logic [c_LVL_W-1:0]  w_level_nxt;
    logic                w_full;
    logic                w_push;
    logic                w_pop;
    logic                w_accept;
    logic                w_timeout;

    // The full check is redundant with r_in_ready but keeps the FIFO safe
    // should the ready register ever lag a pop/push corner case.
    assign w_push = in_valid && r_in_ready && !w_full;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (c_ENT_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_data ({in_dest, in_data}),
        .pop       (w_pop),
        .head      (w_head),
        .level     (w_level),
        .full      (w_full)
    );

    assign w_head_dest = w_head[c_ENT_W-1:DATA_W];
    assign w_head_data = w_head[DATA_W-1:0];

    // Only the addressed destination's ready bit matters.
    assign w_accept  = out_ready[w_head_dest];
    assign w_timeout = (TIMEOUT != 0) && (r_wait_cnt == c_WAIT_LAST);

    always_comb begin
        w_level_nxt = w_level;
        if (w_push && !w_pop) begin
            w_level_nxt = w_level + c_LVL_ONE;
        end else if (!w_push && w_pop) begin
            w_level_nxt = w_level - c_LVL_ONE;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Watchdog counter and registered upstream ready. in_ready looks at the
    // post-edge occupancy, so a pop while full only reopens the input on the
    // following cycle and a push that fills the FIFO closes it immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
            r_in_ready <= 1'b0;
        end else begin
            r_in_ready <= (w_level_nxt < c_LVL_FULL);
            if ((r_state == OFFER) && !w_pop) begin
                r_wait_cnt <= r_wait_cnt + c_WAIT_ONE;
            end else begin
                r_wait_cnt <= '0;
            end
        end
    end

    // Next-state logic. Decisions use the registered level so an incoming
    // word never reaches the outputs in the cycle it is written.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_level != '0) begin
                    w_state_nxt = OFFER;
                end
            end
            OFFER: begin
                if (w_accept) begin
                    if (w_level_nxt == '0) begin
                        w_state_nxt = IDLE;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = DROP;
                end
            end
            DROP: begin
                w_state_nxt = (w_level_nxt == '0) ? IDLE : OFFER;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Output decode. Everything is gated by state so the unreset FIFO storage
    // never leaks onto the outputs.
    always_comb begin
        out_valid = '0;
        out_data  = '0;
        dmx_sel0  = 1'b0;
        dmx_sel1  = 1'b0;
        drop      = 1'b0;
        drop_dest = '0;
        w_pop     = 1'b0;
        unique case (r_state)
            OFFER: begin
                out_valid = dest_onehot(w_head_dest);
                out_data  = w_head_data;
                dmx_sel0  = w_head_dest[1];
                dmx_sel1  = w_head_dest[0];
                w_pop     = w_accept;
            end
            DROP: begin
                drop      = 1'b1;
                drop_dest = w_head_dest;
                w_pop     = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign dmx_i    = |out_valid;
    assign in_ready = r_in_ready;
    assign level    = w_level;

endmodule
`default_nettype wire
